fir_cfg_pipe: RTL



---
 rtl/fir_cfg_pipe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fir_cfg_pipe.sv
// rtl/fir_cfg_pipe.sv - pipelined direct-form FIR with double-buffered runtime coefficients
//
// Purpose: y = sum h[k]*x[k] over TAPS taps, x[0] newest. Coefficients are
// written one word at a time into a shadow bank and swapped atomically into
// the active bank on commit. The output is rounded (half up), arithmetically
// shifted right by SHIFT and saturated to OWIDTH. Fixed latency 4 clocks.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_data     input sample stream (no backpressure)
//   coef_wr, coef_data    shadow-bank write port, h[0] written first
//   coef_commit           shadow-to-active swap request (honoured only when full)
//   coef_ready            shadow bank holds TAPS words
//   out_valid, out_data   filtered output sample
//   out_sat               out_data was clipped
module fir_cfg_pipe #(
  parameter int IWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int TAPS   = 8,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [IWIDTH-1:0] in_data,
  input  logic                     coef_wr,
  input  logic signed [CWIDTH-1:0] coef_data,
  input  logic                     coef_commit,
  output logic                     coef_ready,
  output logic                     out_valid,
  output logic signed [OWIDTH-1:0] out_data,
  output logic                     out_sat
);

  localparam int PW   = IWIDTH + CWIDTH;
  localparam int ACCW = PW + $clog2(TAPS);
  localparam int CNTW = $clog2(TAPS + 1);
  // Compare width large enough to hold both the shifted sum and the clip limits.
  localparam int EW   = (((ACCW + 1) > OWIDTH) ? (ACCW + 1) : OWIDTH) + 1;

  localparam logic [CNTW-1:0]        CNT_LAST = CNTW'(TAPS - 1);
  // 2^(SHIFT-1) when SHIFT>0, zero otherwise.
  localparam logic signed [ACCW:0]   RND  = ({{ACCW{1'b0}}, 1'b1} << SHIFT) >>> 1;
  localparam logic signed [EW-1:0]   OMAX = {{(EW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0]   OMIN = {{(EW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

  typedef enum logic {S_LOAD, S_FULL} state_t;

  state_t                   state, state_next;
  logic [CNTW-1:0]          cnt, cnt_next, wr_idx;
  logic                     wr_en, swap;

  logic signed [CWIDTH-1:0] h_sh  [TAPS];
  logic signed [CWIDTH-1:0] h_act [TAPS];
  logic signed [IWIDTH-1:0] x     [TAPS];
  logic signed [PW-1:0]     prod  [TAPS];
  logic signed [ACCW-1:0]   acc, sum;
  logic signed [ACCW:0]     sum_r, shifted;
  logic signed [EW-1:0]     ext;
  logic signed [OWIDTH-1:0] sat_val;
  logic                     sat_flag;
  logic                     v1, v2, v3;

  assign coef_ready = (state == S_FULL);

  // Coefficient load FSM: next state and shadow write/swap controls.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wr_en      = 1'b0;
    wr_idx     = cnt;
    swap       = 1'b0;
    case (state)
      S_LOAD: begin
        if (coef_wr) begin
          wr_en    = 1'b1;
          cnt_next = cnt + CNTW'(1);
          if (cnt == CNT_LAST) state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (coef_commit) begin
          swap       = 1'b1;
          state_next = S_LOAD;
          // A write on the commit edge starts the next load at h[0].
          wr_idx     = '0;
          wr_en      = coef_wr;
          cnt_next   = coef_wr ? CNTW'(1) : '0;
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_LOAD;
      cnt   <= '0;
      for (int k = 0; k < TAPS; k++) begin
        h_sh[k]  <= '0;
        h_act[k] <= '0;
      end
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      for (int k = 0; k < TAPS; k++) begin
        if (wr_en && (wr_idx == CNTW'(k))) h_sh[k] <= coef_data;
        // Non-blocking read of h_sh gives the pre-edge shadow on a commit+write edge.
        if (swap) h_act[k] <= h_sh[k];
      end
    end
  end

  // Adder tree input: sign-extended products.
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACCW'(prod[k]);
  end

  // Round half up, arithmetic shift, saturate.
  always_comb begin
    sum_r    = {sum[ACCW-1], sum} + RND;
    shifted  = sum_r >>> SHIFT;
    ext      = {{(EW-ACCW-1){shifted[ACCW]}}, shifted};
    sat_flag = 1'b0;
    sat_val  = ext[OWIDTH-1:0];
    if (ext > OMAX) begin
      sat_val  = OMAX[OWIDTH-1:0];
      sat_flag = 1'b1;
    end else if (ext < OMIN) begin
      sat_val  = OMIN[OWIDTH-1:0];
      sat_flag = 1'b1;
    end
  end

  // Datapath: delay line -> products -> sum -> output, each stage gated by
  // its own valid so that history and results hold across input gaps.
  // Products read h_act after the delay-line edge, so a sample accepted on
  // the swap edge sees only the new bank and earlier samples only the old.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      sum       <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        prod[k] <= '0;
      end
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (in_valid) begin
        x[0] <= in_data;
        for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
      end
      if (v1) begin
        for (int k = 0; k < TAPS; k++) prod[k] <= PW'(x[k]) * PW'(h_act[k]);
      end
      if (v2) sum <= acc;
      if (v3) begin
        out_data <= sat_val;
        out_sat  <= sat_flag;
      end
    end
  end

endmodule
